// File: rtl/mesh_pkg.sv
// ============================================================================
//  Module      : mesh_pkg
//  Description : Shared sizes, operand/accumulator types and the multiply-
//                accumulate helper for the 4x4 output-stationary mesh.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mesh_pkg;

    localparam int DIM   = 4;   // rows = columns of PEs
    localparam int IN_W  = 8;   // a/b operand width, signed
    localparam int ACC_W = 16;  // d/c and accumulator width, signed

    typedef logic signed [IN_W-1:0]  operand_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Both operands are sign-extended to the accumulator width before the
    // multiply, so the product is a full signed 16-bit value; the sum wraps.
    function automatic acc_t mac(input acc_t acc, input operand_t a, input operand_t b);
        acc_t w_a_ext;
        acc_t w_b_ext;
        w_a_ext = acc_t'(a);
        w_b_ext = acc_t'(b);
        return acc + (w_a_ext * w_b_ext);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mesh_pe.sv
// ============================================================================
//  Module      : mesh_pe
//  Description : One processing element of the output-stationary mesh.
//                Holds two accumulators (c1/c2); the propagate select decides
//                which one accumulates a*b and which one shifts/preloads.
//  Ports       : clk, rst_n        clock, async active-low reset
//                i_a / o_a         row operand in / registered out (rightward)
//                i_b / o_b         column operand in / registered out (down)
//                i_prop / o_prop   buffer select in / registered out (down)
//                i_d               value loaded into the idle buffer
//                o_c               combinational select of c1/c2
//                o_c_reg           o_c registered one cycle (down, next d)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_pe
    import mesh_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  operand_t i_a,
    input  operand_t i_b,
    input  acc_t     i_d,
    input  logic     i_prop,
    output operand_t o_a,
    output operand_t o_b,
    output logic     o_prop,
    output acc_t     o_c,
    output acc_t     o_c_reg
);

    operand_t r_a;
    operand_t r_b;
    logic     r_prop;
    acc_t     r_c1;
    acc_t     r_c2;
    acc_t     r_c_down;
    acc_t     w_out_c;

    // The buffer being shifted out is the one that is not accumulating.
    assign w_out_c = i_prop ? r_c1 : r_c2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_prop   <= 1'b0;
            r_c1     <= '0;
            r_c2     <= '0;
            r_c_down <= '0;
        end else begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_prop   <= i_prop;
            r_c_down <= w_out_c;
            if (i_prop) begin
                r_c2 <= mac(r_c2, i_a, i_b);
                r_c1 <= i_d;
            end else begin
                r_c1 <= mac(r_c1, i_a, i_b);
                r_c2 <= i_d;
            end
        end
    end

    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_prop  = r_prop;
    assign o_c     = w_out_c;
    assign o_c_reg = r_c_down;

endmodule

`default_nettype wire

// File: rtl/mesh_4x4.sv
// ============================================================================
//  Module      : mesh_4x4
//  Description : 4x4 output-stationary systolic MAC array (C = A*B + D).
//                A enters at the left edge, B / bias D / propagate at the top;
//                results stream out of the bottom row, bottom row first.
//                Operands are expected pre-skewed by the host.
//  Ports       : clock, reset_n                 clock, async active-low reset
//                io_in_a_<i>_0  (8b)            row-i A operand -> PE(i,0)
//                io_in_b_<j>_0  (8b)            column-j B operand -> PE(0,j)
//                io_in_d_<j>_0  (16b)           column-j bias/preload -> PE(0,j)
//                io_in_control_<j>_0_propagate  column-j buffer select
//                io_out_c_<j>_0 (16b)           column-j result from PE(3,j)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_4x4
    import mesh_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [IN_W-1:0]   io_in_a_0_0,
    input  logic [IN_W-1:0]   io_in_a_1_0,
    input  logic [IN_W-1:0]   io_in_a_2_0,
    input  logic [IN_W-1:0]   io_in_a_3_0,
    input  logic [IN_W-1:0]   io_in_b_0_0,
    input  logic [IN_W-1:0]   io_in_b_1_0,
    input  logic [IN_W-1:0]   io_in_b_2_0,
    input  logic [IN_W-1:0]   io_in_b_3_0,
    input  logic [ACC_W-1:0]  io_in_d_0_0,
    input  logic [ACC_W-1:0]  io_in_d_1_0,
    input  logic [ACC_W-1:0]  io_in_d_2_0,
    input  logic [ACC_W-1:0]  io_in_d_3_0,
    input  logic              io_in_control_0_0_propagate,
    input  logic              io_in_control_1_0_propagate,
    input  logic              io_in_control_2_0_propagate,
    input  logic              io_in_control_3_0_propagate,
    output logic [ACC_W-1:0]  io_out_c_0_0,
    output logic [ACC_W-1:0]  io_out_c_1_0,
    output logic [ACC_W-1:0]  io_out_c_2_0,
    output logic [ACC_W-1:0]  io_out_c_3_0
);

    // Edge ports gathered into arrays so the mesh can be generated.
    operand_t w_port_a    [DIM];
    operand_t w_port_b    [DIM];
    acc_t     w_port_d    [DIM];
    logic     w_port_prop [DIM];

    assign w_port_a[0] = io_in_a_0_0;
    assign w_port_a[1] = io_in_a_1_0;
    assign w_port_a[2] = io_in_a_2_0;
    assign w_port_a[3] = io_in_a_3_0;
    assign w_port_b[0] = io_in_b_0_0;
    assign w_port_b[1] = io_in_b_1_0;
    assign w_port_b[2] = io_in_b_2_0;
    assign w_port_b[3] = io_in_b_3_0;
    assign w_port_d[0] = io_in_d_0_0;
    assign w_port_d[1] = io_in_d_1_0;
    assign w_port_d[2] = io_in_d_2_0;
    assign w_port_d[3] = io_in_d_3_0;
    assign w_port_prop[0] = io_in_control_0_0_propagate;
    assign w_port_prop[1] = io_in_control_1_0_propagate;
    assign w_port_prop[2] = io_in_control_2_0_propagate;
    assign w_port_prop[3] = io_in_control_3_0_propagate;

    // Registered outputs of every PE, indexed [row][col].
    operand_t w_a_out    [DIM][DIM];
    operand_t w_b_out    [DIM][DIM];
    logic     w_prop_out [DIM][DIM];
    acc_t     w_c_reg    [DIM][DIM];
    acc_t     w_c_comb   [DIM][DIM];

    for (genvar gi = 0; gi < DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < DIM; gj++) begin : g_col
            operand_t w_a_in;
            operand_t w_b_in;
            acc_t     w_d_in;
            logic     w_prop_in;

            if (gj == 0) begin : g_left_edge
                assign w_a_in = w_port_a[gi];
            end else begin : g_from_left
                assign w_a_in = w_a_out[gi][gj-1];
            end

            if (gi == 0) begin : g_top_edge
                assign w_b_in    = w_port_b[gj];
                assign w_d_in    = w_port_d[gj];
                assign w_prop_in = w_port_prop[gj];
            end else begin : g_from_above
                assign w_b_in    = w_b_out[gi-1][gj];
                assign w_d_in    = w_c_reg[gi-1][gj];
                assign w_prop_in = w_prop_out[gi-1][gj];
            end

            mesh_pe u_pe (
                .clk     (clock),
                .rst_n   (reset_n),
                .i_a     (w_a_in),
                .i_b     (w_b_in),
                .i_d     (w_d_in),
                .i_prop  (w_prop_in),
                .o_a     (w_a_out[gi][gj]),
                .o_b     (w_b_out[gi][gj]),
                .o_prop  (w_prop_out[gi][gj]),
                .o_c     (w_c_comb[gi][gj]),
                .o_c_reg (w_c_reg[gi][gj])
            );
        end
    end

    // Bottom row drives the result streams directly, without an extra register.
    assign io_out_c_0_0 = w_c_comb[DIM-1][0];
    assign io_out_c_1_0 = w_c_comb[DIM-1][1];
    assign io_out_c_2_0 = w_c_comb[DIM-1][2];
    assign io_out_c_3_0 = w_c_comb[DIM-1][3];

endmodule

`default_nettype wire

// File: tb/tb_mesh_4x4.sv
// ============================================================================
//  Module      : tb_mesh_4x4
//  Description : Directed self-checking bench for mesh_4x4. Each scenario is
//                written as per-cycle input vectors plus the expected result
//                stream on the bottom row.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_4x4;

    localparam int NCYC = 24;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  a_drv [4];
    logic [7:0]  b_drv [4];
    logic [15:0] d_drv [4];
    logic        p_drv [4];
    logic [15:0] c_out [4];

    int tests = 0;
    int fails = 0;

    // Per-cycle stimulus and expected-output tables.
    logic [7:0]  sa [NCYC][4];
    logic [7:0]  sb [NCYC][4];
    logic [15:0] sd [NCYC][4];
    logic        sp [NCYC][4];
    logic [15:0] ex [NCYC][4];
    bit          ev [NCYC][4];
    int          ma [4][4];
    int          mb [4][4];

    always #5 clock = ~clock;

    mesh_4x4 dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .io_in_a_0_0                 (a_drv[0]),
        .io_in_a_1_0                 (a_drv[1]),
        .io_in_a_2_0                 (a_drv[2]),
        .io_in_a_3_0                 (a_drv[3]),
        .io_in_b_0_0                 (b_drv[0]),
        .io_in_b_1_0                 (b_drv[1]),
        .io_in_b_2_0                 (b_drv[2]),
        .io_in_b_3_0                 (b_drv[3]),
        .io_in_d_0_0                 (d_drv[0]),
        .io_in_d_1_0                 (d_drv[1]),
        .io_in_d_2_0                 (d_drv[2]),
        .io_in_d_3_0                 (d_drv[3]),
        .io_in_control_0_0_propagate (p_drv[0]),
        .io_in_control_1_0_propagate (p_drv[1]),
        .io_in_control_2_0_propagate (p_drv[2]),
        .io_in_control_3_0_propagate (p_drv[3]),
        .io_out_c_0_0                (c_out[0]),
        .io_out_c_1_0                (c_out[1]),
        .io_out_c_2_0                (c_out[2]),
        .io_out_c_3_0                (c_out[3])
    );

    task automatic check(input string tag, input int col, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s col%0d observed=%h expected=%h", tag, col, obs, expv);
        end
    endtask

    task automatic drive_zero();
        for (int i = 0; i < 4; i++) begin
            a_drv[i] = '0; b_drv[i] = '0; d_drv[i] = '0; p_drv[i] = 1'b0;
        end
    endtask

    task automatic drive_random();
        for (int i = 0; i < 4; i++) begin
            a_drv[i] = 8'($urandom);
            b_drv[i] = 8'($urandom);
            d_drv[i] = 16'($urandom);
            p_drv[i] = 1'($urandom);
        end
    endtask

    task automatic clear_seq();
        for (int t = 0; t < NCYC; t++)
            for (int j = 0; j < 4; j++) begin
                sa[t][j] = '0; sb[t][j] = '0; sd[t][j] = '0;
                sp[t][j] = 1'b0; ex[t][j] = '0; ev[t][j] = 1'b0;
            end
    endtask

    // Reset asserted between clock edges: outputs must clear at once and
    // stay clear under random inputs, then stay clear after release.
    task automatic do_reset(input string tag);
        @(posedge clock); #2;
        reset_n = 1'b0;
        drive_random();
        #1;
        for (int j = 0; j < 4; j++) check({tag, "_async"}, j, c_out[j], 16'h0000);
        repeat (3) begin
            @(posedge clock); #1;
            drive_random();
        end
        #1;
        for (int j = 0; j < 4; j++) check({tag, "_hold"}, j, c_out[j], 16'h0000);
        drive_zero();
        reset_n = 1'b1;
        @(posedge clock); #2;
        for (int j = 0; j < 4; j++) check({tag, "_release"}, j, c_out[j], 16'h0000);
    endtask

    // Cycle t: inputs driven just after a rising edge, outputs sampled 1ns later.
    task automatic run_seq(input string tag, input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clock); #1;
            for (int j = 0; j < 4; j++) begin
                a_drv[j] = sa[t][j]; b_drv[j] = sb[t][j];
                d_drv[j] = sd[t][j]; p_drv[j] = sp[t][j];
            end
            #1;
            for (int j = 0; j < 4; j++)
                if (ev[t][j]) check($sformatf("%s_t%0d", tag, t), j, c_out[j], ex[t][j]);
        end
        drive_zero();
    endtask

    // Skewed feed: row i of A and column j of B delayed by i / j cycles.
    task automatic load_tile(input int base);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                sa[base + i + k][i] = 8'(ma[i][k]);
                sb[base + i + k][i] = 8'(mb[k][i]);
            end
    endtask

    // Column j reads C[3][j]..C[0][j] starting at cycle t0 + j.
    task automatic expect_tile(input int t0);
        int acc;
        for (int j = 0; j < 4; j++)
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc += ma[3 - r][k] * mb[k][j];
                ex[t0 + j + r][j] = 16'(acc);
                ev[t0 + j + r][j] = 1'b1;
            end
    endtask

    task automatic set_b1_identity();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (i == k) ? 1 : 0;
                mb[i][k] = 4 * i + k + 1;
            end
    endtask

    initial begin
        drive_zero();

        // 1. Reset behaviour
        do_reset("reset");

        // 2. Single product 2*3, readout from T=2
        clear_seq();
        sa[0][0] = 8'd2; sb[0][0] = 8'd3;
        for (int t = 2; t < 10; t++) sp[t][0] = 1'b1;
        ex[5][0] = 16'd0; ex[6][0] = 16'd0; ex[7][0] = 16'd0; ex[8][0] = 16'd6;
        for (int t = 5; t < 9; t++) ev[t][0] = 1'b1;
        run_seq("single", 10);

        // 3. Full tile, identity * B, propagate flipped at 4+j
        do_reset("rst3");
        clear_seq();
        set_b1_identity();
        load_tile(0);
        for (int t = 0; t < 16; t++)
            for (int j = 0; j < 4; j++) sp[t][j] = (t >= 4 + j);
        expect_tile(7);
        run_seq("tile", 16);

        // 4. Bias preload of 100 then 2*2 -> 104 in C[0][0], 100 elsewhere in column 0
        do_reset("rst4");
        clear_seq();
        for (int t = 0; t < 4; t++) begin sp[t][0] = 1'b1; sd[t][0] = 16'd100; end
        sa[4][0] = 8'd2; sb[4][0] = 8'd2;
        for (int t = 8; t < 16; t++) sp[t][0] = 1'b1;
        ex[11][0] = 16'd100; ex[12][0] = 16'd100; ex[13][0] = 16'd100; ex[14][0] = 16'd104;
        for (int t = 11; t < 15; t++) ev[t][0] = 1'b1;
        run_seq("bias", 16);

        // 5a. (-128)*(-128) twice wraps to 0x8000
        do_reset("rst5a");
        clear_seq();
        sa[0][0] = 8'h80; sb[0][0] = 8'h80;
        sa[1][0] = 8'h80; sb[1][0] = 8'h80;
        for (int t = 3; t < 10; t++) sp[t][0] = 1'b1;
        ex[9][0] = 16'h8000; ev[9][0] = 1'b1;
        ex[8][0] = 16'h0000; ev[8][0] = 1'b1;
        run_seq("wrap", 10);

        // 5b. (-3)*5 = -15
        do_reset("rst5b");
        clear_seq();
        sa[0][0] = 8'hFD; sb[0][0] = 8'd5;
        for (int t = 2; t < 10; t++) sp[t][0] = 1'b1;
        ex[8][0] = 16'hFFF1; ev[8][0] = 1'b1;
        run_seq("signed", 10);

        // 6. Two back-to-back tiles; the second accumulates while the first drains
        do_reset("rst6");
        clear_seq();
        set_b1_identity();
        load_tile(0);
        expect_tile(7);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = (k == 3 - i) ? 2 : 0;
                mb[i][k] = 3 * k - 5 * i - 7;
            end
        load_tile(4);
        expect_tile(11);
        for (int t = 0; t < 20; t++)
            for (int j = 0; j < 4; j++) sp[t][j] = (t >= 4 + j) && (t < 8 + j);
        run_seq("dbuf", 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
